// File: rtl/kfpga_config_loader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | kfpga_config_loader: streams a bitstream into a shadow register, commits |
// | it to the kFPGA core atomically; optional CRC via KFPGA_CONFIG_CRC_EN.   |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module kfpga_config_loader #(
  parameter int CONFIG_WIDTH = 1602,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    core_nreset,
  output logic                    done,
  output logic                    error
);

  localparam int WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CNT_W = $clog2(WORDS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef KFPGA_CONFIG_CRC_EN
  localparam logic [2:0] S_CRC    = 3'd2;
  localparam logic [2:0] S_ERROR  = 3'd5;
  localparam int CRC_WORDS = (16 + WORD_WIDTH - 1) / WORD_WIDTH;
`endif

  logic [2:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
  logic [CONFIG_WIDTH-1:0] config_q, config_d;
  logic                    nreset_q, nreset_d;
  logic                    done_q, done_d;
  logic                    ready;
  logic                    accept;
`ifdef KFPGA_CONFIG_CRC_EN
  logic [15:0]                       crc_q, crc_d;
  logic [CRC_WORDS*WORD_WIDTH-1:0]   crc_rx_q, crc_rx_d;
  logic                              error_q, error_d;

  // CRC-16-CCITT, one word per call, MSB of the word first
  function automatic logic [15:0] crc_step(input logic [15:0] c,
                                           input logic [WORD_WIDTH-1:0] d);
    logic [15:0] r;
    r = c;
    for (int b = WORD_WIDTH - 1; b >= 0; b--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[b]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      config_q <= '0;
      nreset_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef KFPGA_CONFIG_CRC_EN
      crc_q    <= 16'hFFFF;
      crc_rx_q <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      config_q <= config_d;
      nreset_q <= nreset_d;
      done_q   <= done_d;
`ifdef KFPGA_CONFIG_CRC_EN
      crc_q    <= crc_d;
      crc_rx_q <= crc_rx_d;
      error_q  <= error_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    config_d = config_q;
    nreset_d = nreset_q;
    done_d   = done_q;
    accept   = data_valid & ready;
`ifdef KFPGA_CONFIG_CRC_EN
    crc_d    = crc_q;
    crc_rx_d = crc_rx_q;
    error_d  = error_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
`ifdef KFPGA_CONFIG_CRC_EN
          crc_d   = 16'hFFFF;
`endif
        end else if (accept) begin
          // bits of the final word beyond CONFIG_WIDTH have no destination
          for (int i = 0; i < CONFIG_WIDTH; i++) begin
            if (cnt_q == CNT_W'(i / WORD_WIDTH)) shadow_d[i] = data_in[i % WORD_WIDTH];
          end
`ifdef KFPGA_CONFIG_CRC_EN
          crc_d = crc_step(crc_q, data_in);
`endif
          if (cnt_q == CNT_W'(WORDS - 1)) begin
            cnt_d = '0;
`ifdef KFPGA_CONFIG_CRC_EN
            state_d = S_CRC;
`else
            state_d = S_COMMIT;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef KFPGA_CONFIG_CRC_EN
      S_CRC: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          crc_d   = 16'hFFFF;
        end else if (accept) begin
          for (int j = 0; j < CRC_WORDS; j++) begin
            if (cnt_q == CNT_W'(j)) crc_rx_d[j*WORD_WIDTH +: WORD_WIDTH] = data_in;
          end
          if (cnt_q == CNT_W'(CRC_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = (crc_rx_d[15:0] == crc_q) ? S_COMMIT : S_ERROR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif
      S_COMMIT: begin
        config_d = shadow_q;
        state_d  = S_DONE;
      end
      default: begin
        // IDLE, DONE and ERROR all wait for a new load request
        if (load_start) begin
          state_d  = S_LOAD;
          cnt_d    = '0;
          nreset_d = 1'b0;
          done_d   = 1'b0;
`ifdef KFPGA_CONFIG_CRC_EN
          crc_d    = 16'hFFFF;
          error_d  = 1'b0;
`endif
        end else if (state_q == S_DONE) begin
          nreset_d = 1'b1;
          done_d   = 1'b1;
`ifdef KFPGA_CONFIG_CRC_EN
        end else if (state_q == S_ERROR) begin
          error_d  = 1'b1;
`endif
        end else if (state_q != S_IDLE) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
`ifdef KFPGA_CONFIG_CRC_EN
    ready = (state_q == S_LOAD) || (state_q == S_CRC);
    error = error_q;
`else
    ready = (state_q == S_LOAD);
    error = 1'b0;
`endif
    data_ready  = ready;
    config_out  = config_q;
    core_nreset = nreset_q;
    done        = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_kfpga_config_loader.sv
`default_nettype none
// Directed self-checking bench for kfpga_config_loader at default parameters.
module tb_kfpga_config_loader;

  localparam int CW = 1602;
  localparam int NW = 201;

  logic          clock = 1'b0;
  logic          reset, load_start, data_valid;
  logic [7:0]    data_in;
  logic          data_ready, core_nreset, done, error;
  logic [CW-1:0] config_out;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] crc_m  = 16'hFFFF;

  kfpga_config_loader dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .config_out (config_out),
    .core_nreset(core_nreset),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag, input logic [CW-1:0] e);
    checks++;
    assert (config_out === e) else begin
      errors++;
      $error("FAIL %s: observed low64 0x%h expected low64 0x%h (%0d bits differ)",
             tag, config_out[63:0], e[63:0], $countones(config_out ^ e));
    end
  endtask

  function automatic logic [7:0] word_val(input int mode, input int i);
    case (mode)
      0:       return i[7:0];
      1:       return 8'hFF;
      default: return 8'h33;
    endcase
  endfunction

  function automatic logic [CW-1:0] exp_of(input int mode);
    logic [CW-1:0] e;
    logic [7:0]    w;
    for (int i = 0; i < CW; i++) begin
      w    = word_val(mode, i / 8);
      e[i] = w[i % 8];
    end
    return e;
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      if (r[15] ^ d[b]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  task automatic start_load();
    load_start = 1'b1;
    crc_m      = 16'hFFFF;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_words(input int mode, input int n, input bit bp);
    int         i       = 0;
    int         cyc     = 0;
    int         bubbles = 0;
    logic [7:0] w;
    while (i < n && cyc < 4000) begin
      w = word_val(mode, i);
      if (bp && $urandom_range(0, 1) == 0) begin
        data_valid = 1'b0;
        data_in    = w ^ 8'hA5;
      end else begin
        data_valid = 1'b1;
        data_in    = w;
        crc_m      = crc_step(crc_m, w);
        if (data_ready !== 1'b1) bubbles++;
        i++;
      end
      step();
      cyc++;
    end
    data_valid = 1'b0;
    chk("words_sent", 64'(i), 64'(n));
    chk("ready_during_load", 64'(bubbles), 64'd0);
  endtask

  task automatic send_crc(input bit corrupt);
    logic [15:0] c;
    c = crc_m ^ (corrupt ? 16'h0100 : 16'h0000);
    data_valid = 1'b1;
    data_in    = c[7:0];
    step();
    data_in    = c[15:8];
    step();
    data_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    repeat (3) begin
      load_start = 1'($urandom_range(0, 1));
      data_valid = 1'($urandom_range(0, 1));
      data_in    = 8'($urandom);
      step();
    end
    load_start = 1'b0; data_valid = 1'b0;
    chk_cfg("rst_config", '0);
    chk("rst_nreset", core_nreset, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ready", data_ready, 0);
    reset = 1'b0;

    data_valid = 1'b1; data_in = 8'h5A;
    repeat (3) step();
    chk("idle_ignores_words", data_ready, 0);
    data_valid = 1'b0;

    // continuous load, word i = i
    start_load();
    chk("ready_after_start", data_ready, 1);
    chk("nreset_after_start", core_nreset, 0);
    send_words(0, NW, 0);
`ifdef KFPGA_CONFIG_CRC_EN
    send_crc(0);
`endif
    chk("done_at_n", done, 0);
    step();
    chk("done_at_n1", done, 0);
    chk_cfg("cfg_at_n1", exp_of(0));
    step();
    chk("done_at_n2", done, 1);
    chk("nreset_at_n2", core_nreset, 1);
    chk("cfg_byte0", config_out[7:0], 8'h00);
    chk("cfg_byte1", config_out[15:8], 8'h01);
    chk("cfg_byte199", config_out[1599:1592], 8'hC7);
    chk("cfg_top2", config_out[1601:1600], 2'b00);

    // restart after 50 words, with a word offered in the restart cycle
    start_load();
    chk("restart_nreset_low", core_nreset, 0);
    chk("restart_done_low", done, 0);
    send_words(2, 50, 0);
    load_start = 1'b1; data_valid = 1'b1; data_in = 8'h00; crc_m = 16'hFFFF;
    step();
    load_start = 1'b0; data_valid = 1'b0;
    send_words(1, NW, 0);
`ifdef KFPGA_CONFIG_CRC_EN
    send_crc(0);
`endif
    step(); step();
    chk("restart_done", done, 1);
    chk_cfg("restart_all_ones", {CW{1'b1}});

    // backpressure
    start_load();
    send_words(0, NW, 1);
`ifdef KFPGA_CONFIG_CRC_EN
    send_crc(0);
`endif
    step(); step();
    chk("bp_done", done, 1);
    chk_cfg("bp_config", exp_of(0));

`ifdef KFPGA_CONFIG_CRC_EN
    // corrupted CRC blocks the commit
    start_load();
    send_words(1, NW, 0);
    send_crc(1);
    step();
    chk("crc_bad_error", error, 1);
    chk("crc_bad_done", done, 0);
    chk("crc_bad_nreset", core_nreset, 0);
    chk_cfg("crc_bad_config_kept", exp_of(0));
    start_load();
    chk("error_cleared", error, 0);
    send_words(1, NW, 0);
    send_crc(0);
    step(); step();
    chk("crc_good_done", done, 1);
    chk_cfg("crc_good_config", {CW{1'b1}});
`endif

    // reset in the middle of a load
    start_load();
    send_words(0, 100, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_cfg("midrst_config", '0);
    chk("midrst_nreset", core_nreset, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", data_ready, 0);
    data_valid = 1'b1; data_in = 8'h77;
    repeat (5) step();
    chk("midrst_no_accept", data_ready, 0);
    data_valid = 1'b0;
    start_load();
    chk("midrst_ready_after_start", data_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
